// File: rtl/cache_miss_ctrl_pkg.sv
// rtl/cache_miss_ctrl_pkg.sv - shared state encoding, address split and PLRU bit roles
package cache_miss_ctrl_pkg;

  localparam int ADDR_BITS = 32;
  localparam int OFF_BITS  = 5;

  // Tree PLRU: bit 0 chooses the pair, bits 1/2 choose within pair {0,1}/{2,3}
  localparam int PLRU_PAIR = 0;
  localparam int PLRU_LO   = 1;
  localparam int PLRU_HI   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_UPDATE,
    ST_REPLAY
  } state_t;

endpackage

// File: rtl/cache_miss_ctrl_plru_victim.sv
// rtl/cache_miss_ctrl_plru_victim.sv - 4-way victim pick and PLRU update, combinational
module cache_miss_ctrl_plru_victim
  import cache_miss_ctrl_pkg::*;
(
  input  logic [3:0] val,
  input  logic [2:0] lru,
  output logic [3:0] victim,
  input  logic [3:0] upd_way,
  input  logic [2:0] upd_lru_in,
  output logic [2:0] upd_lru
);

  always_comb begin
    victim = 4'b0000;
    if (!val[0])             victim = 4'b0001;
    else if (!val[1])        victim = 4'b0010;
    else if (!val[2])        victim = 4'b0100;
    else if (!val[3])        victim = 4'b1000;
    else if (!lru[PLRU_PAIR]) victim = lru[PLRU_LO] ? 4'b0010 : 4'b0001;
    else                     victim = lru[PLRU_HI] ? 4'b1000 : 4'b0100;
  end

  // Point the tree away from the way just filled; the other subtree bit is kept
  always_comb begin
    upd_lru = upd_lru_in;
    if (upd_way[0]) begin
      upd_lru[PLRU_PAIR] = 1'b1;
      upd_lru[PLRU_LO]   = 1'b1;
    end else if (upd_way[1]) begin
      upd_lru[PLRU_PAIR] = 1'b1;
      upd_lru[PLRU_LO]   = 1'b0;
    end else if (upd_way[2]) begin
      upd_lru[PLRU_PAIR] = 1'b0;
      upd_lru[PLRU_HI]   = 1'b1;
    end else if (upd_way[3]) begin
      upd_lru[PLRU_PAIR] = 1'b0;
      upd_lru[PLRU_HI]   = 1'b0;
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - L1 line-miss sequencer: victim pick, writeback, fill, array update, replay
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter int TAG_BITS  = 14,
  parameter int IDX_BITS  = 13,
  parameter int WAYS      = 4,
  parameter int LINE_BITS = 256,
  parameter int CNT_BITS  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  logic                     req_miss,
  input  logic [ADDR_BITS-1:0]     req_addr,
  input  logic [WAYS-1:0]          val_in,
  input  logic [WAYS-1:0]          mod_in,
  input  logic [2:0]               lru_in,
  input  logic [WAYS*TAG_BITS-1:0] tag_in,
  input  logic [LINE_BITS-1:0]     evict_data,
  input  logic                     mm_waitrequest,
  input  logic [LINE_BITS-1:0]     mm_rd,
  input  logic                     mm_readdata_valid,
  output logic                     stall,
  output logic [ADDR_BITS-1:0]     mm_a,
  output logic                     mm_read,
  output logic                     mm_write,
  output logic [LINE_BITS-1:0]     mm_wd,
  output logic                     fill,
  output logic [WAYS-1:0]          fill_way,
  output logic [LINE_BITS-1:0]     fill_data,
  output logic [WAYS-1:0]          tag_write,
  output logic [TAG_BITS-1:0]      tag_wd,
  output logic                     val_set,
  output logic                     mod_clr,
  output logic                     lru_write,
  output logic [2:0]               lru_wd,
  output logic                     replay,
  output logic [CNT_BITS-1:0]      miss_cnt,
  output logic [CNT_BITS-1:0]      wb_cnt
);

  state_t                state;
  logic [IDX_BITS-1:0]   idx_q;
  logic [TAG_BITS-1:0]   req_tag_q;
  logic [WAYS-1:0]       victim_q;
  logic [2:0]            lru_q;

  logic [IDX_BITS-1:0]   req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [WAYS-1:0]       victim;
  logic [TAG_BITS-1:0]   victim_tag;
  logic                  victim_dirty;
  logic [2:0]            lru_next;
  logic                  data_done;
  logic                  unused_offset;

  assign req_idx       = req_addr[OFF_BITS +: IDX_BITS];
  assign req_tag       = req_addr[OFF_BITS+IDX_BITS +: TAG_BITS];
  assign unused_offset = ^req_addr[OFF_BITS-1:0];

  cache_miss_ctrl_plru_victim u_plru (
    .val        (val_in),
    .lru        (lru_in),
    .victim     (victim),
    .upd_way    (victim_q),
    .upd_lru_in (lru_q),
    .upd_lru    (lru_next)
  );

  always_comb begin
    victim_tag = '0;
    for (int w = 0; w < WAYS; w++)
      if (victim[w]) victim_tag = tag_in[w*TAG_BITS +: TAG_BITS];
  end

  assign victim_dirty = |(victim & val_in & mod_in);

  // Fill data may arrive together with the read accept or later in FILL_WAIT
  assign data_done = mm_readdata_valid &&
                     ((state == ST_FILL_REQ && !mm_waitrequest) || state == ST_FILL_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      req_tag_q <= '0;
      victim_q  <= '0;
      lru_q     <= '0;
      stall     <= 1'b0;
      mm_a      <= '0;
      mm_read   <= 1'b0;
      mm_write  <= 1'b0;
      mm_wd     <= '0;
      fill      <= 1'b0;
      fill_way  <= '0;
      fill_data <= '0;
      tag_write <= '0;
      tag_wd    <= '0;
      val_set   <= 1'b0;
      mod_clr   <= 1'b0;
      lru_write <= 1'b0;
      lru_wd    <= '0;
      replay    <= 1'b0;
      miss_cnt  <= '0;
      wb_cnt    <= '0;
    end else begin
      fill      <= 1'b0;
      fill_way  <= '0;
      tag_write <= '0;
      val_set   <= 1'b0;
      mod_clr   <= 1'b0;
      lru_write <= 1'b0;
      replay    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req_valid && req_miss) begin
            idx_q     <= req_idx;
            req_tag_q <= req_tag;
            victim_q  <= victim;
            lru_q     <= lru_in;
            mm_wd     <= evict_data;
            stall     <= 1'b1;
            miss_cnt  <= (&miss_cnt) ? miss_cnt : miss_cnt + 1'b1;
            if (victim_dirty) begin
              state    <= ST_WB_REQ;
              mm_write <= 1'b1;
              mm_a     <= {victim_tag, req_idx, {OFF_BITS{1'b0}}};
            end else begin
              state    <= ST_FILL_REQ;
              mm_read  <= 1'b1;
              mm_a     <= {req_tag, req_idx, {OFF_BITS{1'b0}}};
            end
          end
        end
        ST_WB_REQ: begin
          if (!mm_waitrequest) begin
            state    <= ST_FILL_REQ;
            mm_write <= 1'b0;
            mm_read  <= 1'b1;
            mm_a     <= {req_tag_q, idx_q, {OFF_BITS{1'b0}}};
            wb_cnt   <= (&wb_cnt) ? wb_cnt : wb_cnt + 1'b1;
          end
        end
        ST_FILL_REQ: begin
          if (!mm_waitrequest) begin
            mm_read <= 1'b0;
            state   <= mm_readdata_valid ? ST_UPDATE : ST_FILL_WAIT;
          end
        end
        ST_FILL_WAIT: begin
          if (mm_readdata_valid) state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          state  <= ST_REPLAY;
          stall  <= 1'b0;
          replay <= 1'b1;
        end
        ST_REPLAY: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase

      if (data_done) begin
        fill_data <= mm_rd;
        fill      <= 1'b1;
        fill_way  <= victim_q;
        tag_write <= victim_q;
        tag_wd    <= req_tag_q;
        val_set   <= 1'b1;
        mod_clr   <= 1'b1;
        lru_write <= 1'b1;
        lru_wd    <= lru_next;
      end
    end
  end

endmodule
